nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 20 ++
 rtl/nibble_serial_adder_if.sv | 32 +++
 rtl/nibble_serial_adder_cla4.sv | 36 +++
 rtl/nibble_serial_adder.sv | 137 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// Holds the controller state encoding, the nibble width, the default
// nibble count and the two's-complement overflow helper.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int DEFAULT_NIBBLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow: both addends share a sign and the result's sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// Ports carried:
//   in_valid/in_ready   operand handshake (producer -> adder)
//   a, b, cin           operands, W bits each plus carry-in
//   out_valid/out_ready result handshake (adder -> consumer)
//   sum, cout, ovf      result, unsigned carry-out, signed overflow
// master: the side driving operands and consuming results (testbench/system).
// slave : the adder itself.
interface nibble_serial_adder_if #(
    parameter int W = nibble_serial_adder_pkg::NIBBLE_W * nibble_serial_adder_pkg::DEFAULT_NIBBLES
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder used as the only arithmetic element of the
// nibble-serial adder.
// Ports:
//   a, b  4-bit addends
//   cin   carry-in
//   sum   4-bit sum
//   cout  carry out of bit 3
module nibble_serial_adder_cla4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);
    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [4:0] c_s;

    // Generate/propagate terms and fully expanded lookahead carries.
    always_comb begin
        p_s    = a ^ b;
        g_s    = a & b;
        c_s[0] = cin;
        c_s[1] = g_s[0] | (p_s[0] & cin);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & cin);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);
        sum    = p_s ^ c_s[3:0];
        cout   = c_s[4];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: accepts a W-bit operand pair plus carry-in, adds one
// nibble per clock through a single 4-bit CLA, then presents sum, unsigned
// carry-out and two's-complement overflow until the consumer takes them.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of nibble_serial_adder_if (operand and result handshakes)
// All outputs come from registers; the CLA sees only registered operands.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = DEFAULT_NIBBLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_adder_if.slave     bus
);
    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e state_r;
    state_e state_nxt_s;

    // Operands and sum kept as nibble arrays so idx selects a nibble directly.
    logic [NIBBLES-1:0][NIBBLE_W-1:0] a_r;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] b_r;
    logic [NIBBLES-1:0][NIBBLE_W-1:0] sum_r;
    logic [IDX_W-1:0]                 idx_r;
    logic                             carry_r;
    logic                             cout_r;
    logic                             ovf_r;

    logic [NIBBLE_W-1:0] cla_sum_s;
    logic                cla_cout_s;
    logic                accept_s;
    logic                last_s;

    assign accept_s = (state_r == IDLE) && bus.in_valid;
    assign last_s   = (idx_r == IDX_LAST);

    nibble_serial_adder_cla4 u_cla (
        .a    (a_r[idx_r]),
        .b    (b_r[idx_r]),
        .cin  (carry_r),
        .sum  (cla_sum_s),
        .cout (cla_cout_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state logic; results are never overlapped with a new capture.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = ADD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADD: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_r)
            IDLE:    bus.in_ready  = 1'b1;
            ADD:     bus.in_ready  = 1'b0;
            DONE:    bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Datapath: operand capture, per-nibble accumulate, final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            idx_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            sum_r   <= '0;
            idx_r   <= '0;
            carry_r <= bus.cin;
        end else if (state_r == ADD) begin
            sum_r[idx_r] <= cla_sum_s;
            carry_r      <= cla_cout_s;
            idx_r        <= idx_r + IDX_ONE;
            // Flags latched on the last nibble so they hold through DONE and IDLE.
            if (last_s) begin
                cout_r <= cla_cout_s;
                ovf_r  <= add_ovf(a_r[NIBBLES-1][NIBBLE_W-1],
                                  b_r[NIBBLES-1][NIBBLE_W-1],
                                  cla_sum_s[NIBBLE_W-1]);
            end
        end
    end

    assign bus.sum  = W'(sum_r);
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized self-checking bench for nibble_serial_adder (NIBBLES=4).
module tb_nibble_serial_adder;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    nibble_serial_adder_if #(.W(16)) bus ();

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands in IDLE for one edge, then withdraw them.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        step();
        bus.in_valid = 1'b0;
    endtask

    // Edges after the accepting edge until out_valid, bounded.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 20) begin
            step();
            edges++;
        end
        if (!bus.out_valid) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [15:0] e_sum,
                           input logic e_cout, input logic e_ovf);
        int edges;
        bus.out_ready = 1'b1;
        accept(a, b, cin);
        wait_result(edges);
        chk({tag, "_sum"},  32'(bus.sum),  32'(e_sum));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(e_cout));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(e_ovf));
        step();
        chk({tag, "_rdy"},  32'(bus.in_ready), 32'd1);
    endtask

    logic [32:0] q[$];

    initial begin
        int          edges;
        int          sent;
        int          recv;
        int          cyc;
        logic        acc;
        logic [32:0] e;
        logic [16:0] full;
        logic [17:0] exp_r;

        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       32'(bus.sum),       32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        rst_n = 1'b1;
        step();

        // Basic add; latency counts the accepting edge plus four adding edges.
        bus.out_ready = 1'b1;
        accept(16'h1234, 16'h4321, 1'b0);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        wait_result(edges);
        chk("lat_edges", 32'(edges), 32'd4);
        chk("t1_sum",  32'(bus.sum),  32'h5555);
        chk("t1_cout", 32'(bus.cout), 32'd0);
        chk("t1_ovf",  32'(bus.ovf),  32'd0);
        chk("t1_rdy_done", 32'(bus.in_ready), 32'd0);
        step();
        chk("t1_rdy",  32'(bus.in_ready),  32'd1);
        chk("t1_ovld", 32'(bus.out_valid), 32'd0);
        chk("t1_hold", 32'(bus.sum),       32'h5555);

        run_txn("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_txn("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_txn("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Reset after the second adding edge aborts the transaction.
        accept(16'hAAAA, 16'h5555, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.in_ready),  32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum",   32'(bus.sum),       32'd0);
        chk("mid_rst_cout",  32'(bus.cout),      32'd0);
        chk("mid_rst_ovf",   32'(bus.ovf),       32'd0);
        step();
        rst_n = 1'b1;
        run_txn("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Backpressure: result held ten cycles while inputs churn.
        bus.out_ready = 1'b0;
        accept(16'h1111, 16'h2222, 1'b1);
        wait_result(edges);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'(i % 2);
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.cin      = 1'($urandom);
            step();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_ready", 32'(bus.in_ready),  32'd0);
            chk("bp_sum",   32'(bus.sum),       32'h3334);
            chk("bp_flags", 32'({bus.cout, bus.ovf}), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'h0001;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_rdy", 32'(bus.in_ready),  32'd1);
        chk("bp_release_vld", 32'(bus.out_valid), 32'd0);
        chk("bp_no_capture",  32'(bus.sum),       32'h3334);
        bus.in_valid = 1'b0;
        step();
        chk("bp_idle_hold",   32'(bus.sum),       32'h3334);

        // Random back-to-back with a scoreboard queue.
        sent = 0;
        recv = 0;
        cyc  = 0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        bus.cin       = 1'($urandom);
        bus.out_ready = 1'b0;
        while (recv < 1000 && cyc < 30000) begin
            acc = bus.in_ready && bus.in_valid;
            if (acc) begin
                q.push_back({bus.a, bus.b, bus.cin});
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra", 32'd1, 32'd0);
                end else begin
                    e     = q.pop_front();
                    full  = {1'b0, e[32:17]} + {1'b0, e[16:1]} + {16'd0, e[0]};
                    exp_r = {full[16],
                             (e[32] == e[16]) && (full[15] != e[32]),
                             full[15:0]};
                    chk("rnd", 32'({bus.cout, bus.ovf, bus.sum}), 32'(exp_r));
                end
                recv++;
            end
            step();
            cyc++;
            if (acc) begin
                if (sent < 1000) begin
                    bus.a   = 16'($urandom);
                    bus.b   = 16'($urandom);
                    bus.cin = 1'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        chk("rnd_count", 32'(recv), 32'd1000);
        chk("rnd_left",  32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
